// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory responder: I/O window select, register addresses, RAM size.
package mem_io_pkg;
  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam int          RAM_AW       = 17;
  localparam int          RAM_BYTES    = 1 << RAM_AW;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push/pop visible next cycle, push dropped when full.
// Head is zeroed when empty; afull is a registered view of the post-edge occupancy.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       afull
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(AFULL_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_d;
  logic             afull_q, afull_d;
  logic             push_en, pop_en;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_en = push_vld && !full;
  assign pop_en  = pop_rdy && !empty;
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign afull   = afull_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_en};
    count_d  = wr_ptr_d - rd_ptr_d;
    afull_d  = (count_d >= AFULL_CNT);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
  end
endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: RAM plus UART/counter/stop I/O, read data registered one cycle after request.
// No wait states; the core throttles TX writes on io_buffer_full, pushes into a full FIFO are dropped.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = RAM_AW,
  parameter int TX_FIFO_DEPTH  = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        program_stop
);
  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic [7:0]  ram_q [2**RAM_ADDR_WIDTH];
  logic [7:0]  ram_rd;
  logic [17:0] io_addr;
  logic        is_io, rd_uart, wr_uart, wr_clk;
  logic        tx_push_vld;
  logic [7:0]  tx_push_dat;
  logic        tx_empty, tx_full;
  logic [CNT_W-1:0] tx_count;

  logic [7:0]  mem_din_q, mem_din_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_snap_q, cnt_snap_d;
  logic        program_stop_q, program_stop_d;
  logic        unused_ok;

  assign io_addr = mem_a[17:0];
  assign is_io   = (mem_a[17:16] == IO_SEL);
  assign ram_rd  = ram_q[mem_a[RAM_ADDR_WIDTH-1:0]];
  assign rd_uart = !mem_wr && is_io && (io_addr == IO_UART_ADDR);
  assign wr_uart =  mem_wr && is_io && (io_addr == IO_UART_ADDR);
  assign wr_clk  =  mem_wr && is_io && (io_addr == IO_CLK_ADDR);

  // 0x00 is reserved as the end-of-program marker, so plain UART writes of 0 are dropped.
  assign tx_push_vld = (wr_uart && (mem_dout != 8'h00)) || wr_clk;
  assign tx_push_dat = wr_clk ? 8'h00 : mem_dout;

  // Gated by reset so the pulse cannot leak while the block is held in reset.
  assign rx_pop       = rd_uart && rx_valid && rst_in;
  assign mem_din      = mem_din_q;
  assign program_stop = program_stop_q;
  assign tx_valid     = !tx_empty;
  assign unused_ok    = ^{mem_a[31:18], tx_full, tx_count};

  always_comb begin
    mem_din_d      = mem_din_q;
    cnt_snap_d     = cnt_snap_q;
    cnt_d          = program_stop_q ? cnt_q : cnt_q + 32'd1;
    program_stop_d = program_stop_q || wr_clk;
    if (!mem_wr) begin
      if (!is_io) begin
        mem_din_d = ram_rd;
      end else begin
        case (io_addr)
          IO_UART_ADDR: mem_din_d = rx_valid ? rx_data : 8'h00;
          IO_CLK_ADDR: begin
            // Low byte comes live; the snapshot keeps the upper bytes coherent with it.
            mem_din_d  = cnt_q[7:0];
            cnt_snap_d = cnt_q;
          end
          IO_CLK_ADDR + 18'd1: mem_din_d = cnt_snap_q[15:8];
          IO_CLK_ADDR + 18'd2: mem_din_d = cnt_snap_q[23:16];
          IO_CLK_ADDR + 18'd3: mem_din_d = cnt_snap_q[31:24];
          default:             mem_din_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q      <= 8'h00;
      cnt_q          <= 32'd0;
      cnt_snap_q     <= 32'd0;
      program_stop_q <= 1'b0;
    end else begin
      mem_din_q      <= mem_din_d;
      cnt_q          <= cnt_d;
      cnt_snap_q     <= cnt_snap_d;
      program_stop_q <= program_stop_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io) ram_q[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
  end

  // Two-entry margin: one cycle for the core to see the flag plus one write already in flight.
  sync_fifo #(
    .WIDTH     (8),
    .DEPTH     (TX_FIFO_DEPTH),
    .AFULL_LVL (TX_FIFO_DEPTH - 2)
  ) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_vld (tx_push_vld),
    .push_dat (tx_push_dat),
    .pop_rdy  (tx_ready),
    .pop_dat  (tx_data),
    .count    (tx_count),
    .full     (tx_full),
    .empty    (tx_empty),
    .afull    (io_buffer_full)
  );
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX FIFO, RX pop, cycle counter, stop and async reset.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h123;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_pop;
  logic        program_stop;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop)
  );

  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic w);
    mem_a = a; mem_dout = d; mem_wr = w;
  endtask

  task automatic idle();
    drive(32'h0000_0123, 8'h00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic restart();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #2 rst_in = 1'b1;
  endtask

  task automatic test_reset();
    #23;
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_mem_din got %h want 00", mem_din); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", io_buffer_full); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rst_rx_pop got %b want 0", rx_pop); end
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL rst_stop got %b want 0", program_stop); end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    drive(32'h0000_0123, 8'hA5, 1'b1); tick();
    drive(32'h0000_0123, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_123 got %h want a5", mem_din); end
    drive(32'h0001_FFFF, 8'h3C, 1'b1); tick();
    drive(32'h0001_FFFF, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_1ffff got %h want 3c", mem_din); end
    drive(32'h0002_0123, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_alias got %h want a5", mem_din); end
    drive(32'h0001_FFFF, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_b2b_1 got %h want 3c", mem_din); end
    drive(32'h0000_0123, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_b2b_2 got %h want a5", mem_din); end
  endtask

  task automatic test_tx();
    tx_ready = 1'b1;
    drive(32'h0003_0000, 8'h48, 1'b1); tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin errors++; $display("FAIL tx_h got v=%b d=%h want v=1 d=48", tx_valid, tx_data); end
    drive(32'h0003_0000, 8'h00, 1'b1); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_zero got v=%b d=%h want v=0", tx_valid, tx_data); end
    drive(32'h0003_0000, 8'h69, 1'b1); tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin errors++; $display("FAIL tx_i got v=%b d=%h want v=1 d=69", tx_valid, tx_data); end
    idle(); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] b;
    logic       exp_full;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'(8'h10 + i);
      drive(32'h0003_0000, b, 1'b1); tick();
      if (i == 12) begin
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_at13 got %b want 0", io_buffer_full); end
      end
      if (i == 13) begin
        checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_at14 got %b want 1", io_buffer_full); end
      end
    end
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'(8'h10 + i);
      checks++; if (tx_valid !== 1'b1 || tx_data !== b) begin errors++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, b); end
      tick();
      exp_full = ((15 - i) >= 14);
      checks++; if (io_buffer_full !== exp_full) begin errors++; $display("FAIL drain_full_%0d got %b want %b", i, io_buffer_full, exp_full); end
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop17 got v=%b d=%h want v=0", tx_valid, tx_data); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h7E;
    drive(32'h0003_0000, 8'h00, 1'b0); #1;
    checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_on got %b want 1", rx_pop); end
    tick();
    idle(); #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_pulse got %b want 0", rx_pop); end
    checks++; if (mem_din !== 8'h7E) begin errors++; $display("FAIL rx_data got %h want 7e", mem_din); end
    tick();
    rx_valid = 1'b0;
    drive(32'h0003_0000, 8'h00, 1'b0); #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_nopop got %b want 0", rx_pop); end
    tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty got %h want 00", mem_din); end
    idle(); tick();
  endtask

  task automatic test_io_misc();
    tx_ready = 1'b0;
    drive(32'h0003_0008, 8'h55, 1'b1); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_wr got %b want 0", tx_valid); end
    idle(); tick();
    drive(32'h0003_0008, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL io_other_rd got %h want 00", mem_din); end
    drive(32'hABC3_0000, 8'h77, 1'b1); tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL io_alias got v=%b d=%h want v=1 d=77", tx_valid, tx_data); end
    idle(); tx_ready = 1'b1; tick(); tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    idle();
    restart();
    repeat (255) @(posedge clk_in);
    #1;
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'hFF) begin errors++; $display("FAIL cnt_b0 got %h want ff", mem_din); end
    drive(32'h0003_0005, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_b1 got %h want 00", mem_din); end
    drive(32'h0003_0006, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_b2 got %h want 00", mem_din); end
    drive(32'h0003_0007, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_b3 got %h want 00", mem_din); end
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h03) begin errors++; $display("FAIL cnt_resnap_b0 got %h want 03", mem_din); end
    drive(32'h0003_0005, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL cnt_resnap_b1 got %h want 01", mem_din); end
    idle();
  endtask

  task automatic test_stop_reset();
    idle();
    tx_ready = 1'b0;
    restart();
    repeat (20) @(posedge clk_in);
    #1;
    drive(32'h0003_0004, 8'hAA, 1'b1); tick();
    checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_set got %b want 1", program_stop); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL stop_push got v=%b d=%h want v=1 d=00", tx_valid, tx_data); end
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h15) begin errors++; $display("FAIL stop_cnt got %h want 15", mem_din); end
    idle();
    repeat (10) tick();
    drive(32'h0003_0005, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL stop_cnt_b1 got %h want 00", mem_din); end
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    checks++; if (mem_din !== 8'h15) begin errors++; $display("FAIL stop_frozen got %h want 15", mem_din); end
    drive(32'h0003_0004, 8'h00, 1'b1); tick();
    drive(32'h0003_0000, 8'h41, 1'b1); tick();
    drive(32'h0003_0000, 8'h42, 1'b1); tick();
    checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_sticky got %b want 1", program_stop); end
    idle(); tx_ready = 1'b1; tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL stop_second_zero got v=%b d=%h want v=1 d=00", tx_valid, tx_data); end
    tick();
    checks++; if (tx_data !== 8'h41 || mem_din !== 8'hA5) begin errors++; $display("FAIL middrain got d=%h din=%h want d=41 din=a5", tx_data, mem_din); end
    #2;
    rx_valid = 1'b1; rx_data = 8'h5A;
    drive(32'h0003_0000, 8'h00, 1'b0);
    rst_in = 1'b0; #1;
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL arst_mem_din got %h want 00", mem_din); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL arst_tx got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL arst_stop got %b want 0", program_stop); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL arst_full got %b want 0", io_buffer_full); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL arst_rx_pop got %b want 0", rx_pop); end
    rx_valid = 1'b0;
    idle();
    tick();
    rst_in = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL arst_discard got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_full();
    test_rx();
    test_io_misc();
    test_counter();
    test_stop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it consumes `mem_a`/`mem_dout`/`mem_wr` from the core and returns `mem_din` one cycle later. It holds the 128 KB program/data RAM and the memory-mapped I/O hub: UART TX FIFO, UART RX pop, cycle counter and program-stop. It drives `io_buffer_full` back to the core and sits between the CPU top and the UART/host interface in the system top.

## Interface

**Parameters**
- `RAM_ADDR_WIDTH`, default 17: RAM byte-address width (2^17 bytes).
- `TX_FIFO_DEPTH`, default 16: TX FIFO entries; must be a power of two and ≥ 4.

**Ports**
- `clk_in`, input, 1: single clock.
- `rst_in`, input, 1: reset, asynchronous and active-low.
- `mem_a`, input, 32: byte address from the CPU.
- `mem_dout`, input, 8: write data from the CPU.
- `mem_wr`, input, 1: 1 = write, 0 = read.
- `mem_din`, output, 8: read data to the CPU, registered.
- `io_buffer_full`, output, 1: TX FIFO near full, registered.
- `tx_valid`, output, 1: TX FIFO head valid.
- `tx_data`, output, 8: TX FIFO head byte.
- `tx_ready`, input, 1: UART accepts the head byte.
- `rx_valid`, input, 1: UART RX byte available.
- `rx_data`, input, 8: UART RX byte.
- `rx_pop`, output, 1: one-cycle pulse that consumes `rx_data`.
- `program_stop`, output, 1: sticky, set by the stop write.

## Operation
- **Decode:** `is_io = (mem_a[17:16] == 2'b11)`. Otherwise RAM, indexed by `mem_a[RAM_ADDR_WIDTH-1:0]`. Upper address bits are ignored.
- **RAM write** (`mem_wr=1`, `!is_io`): the byte is stored at the clock edge.
- **RAM read** (`mem_wr=0`, `!is_io`): `mem_din` at edge N+1 holds `ram[a]`. RAM contents are not reset.
- **Write 0x30000:** a nonzero byte is pushed to the TX FIFO. `0x00` is ignored. A push while the FIFO is full is dropped, with no other side effect.
- **Write 0x30004:** sets `program_stop`, pushes `0x00` to the TX FIFO (subject to the same full rule), and freezes the cycle counter.
- **Read 0x30000:** if `rx_valid`, `mem_din` ← `rx_data` and `rx_pop` pulses in the same cycle as the request. Otherwise `mem_din` ← `0x00` and there is no pop.
- **Pop contract:** a pop occurs on every cycle that a read of 0x30000 is presented. The core presents 0x30000 for exactly one cycle per byte read.
- **Cycle counter:** 32-bit, cleared at reset, increments every cycle while `!program_stop`, wraps at 2^32.
- **Read 0x30004:** snapshots the counter into `cnt_snap` and returns bit 7:0 of the live counter value.
- **Read 0x30005/6/7:** return `cnt_snap` bytes 1/2/3. A 4-byte read starting at 0x30004 is therefore coherent.
- **Other I/O addresses:** reads return `0x00`; writes are ignored.
- **TX FIFO:** `tx_valid = !empty`, `tx_data = head`. A pop occurs when `tx_valid && tx_ready`. A simultaneous push and pop both take effect, leaving the count unchanged. A push to an empty FIFO becomes visible on `tx_valid` the next cycle.
- **`io_buffer_full`:** registered `count >= TX_FIFO_DEPTH-2`. The 2-entry margin covers the core's one-cycle reaction plus one in-flight write.

## Timing
- **Reset values:** `mem_din=0`, `io_buffer_full=0`, `tx_valid=0`, `tx_data=0`, `rx_pop=0`, `program_stop=0`; counter 0, `cnt_snap` 0, FIFO empty.
- **Read latency:** exactly 1 cycle for RAM and all I/O. Writes complete at the request edge; there are no wait states.
- **Back-to-back reads:** one read per cycle to any mix of addresses is sustained.
- **`io_buffer_full` update:** reflects the FIFO count after the previous edge's push and pop.
- **Reset mid-operation:** asserting reset clears all state asynchronously. Any in-flight `mem_din` is lost, and FIFO contents are discarded.
- **`program_stop`:** stays 1 until reset. Further 0x30004 writes push another `0x00` but have no other effect.

## Structure
- **Shared package `mem_io_pkg`:** `IO_SEL = 2'b11`, `IO_UART_ADDR = 18'h30000`, `IO_CLK_ADDR = 18'h30004`, and the RAM size constant.
- **Sub-module `sync_fifo`:** parameterised width/depth, with ptr + 1-bit wrap, `count`, `full` and `empty`. Used for TX.
- **Top of this block:** address decode, RAM array, output register, counter/snapshot, and stop logic.

## Test plan
- **RAM round trip:** write `0xA5` to 0x00123, then read 0x00123 → `mem_din = 0xA5` exactly one cycle later. Read 0x1FFFF after writing `0x3C` → `0x3C`.
- **TX push/drain:** writes `0x48`, `0x00`, `0x69` to 0x30000 with `tx_ready=1` → `tx_data` shows `0x48` then `0x69`; `0x00` is never emitted.
- **Full flag:** `tx_ready=0`, write 14 nonzero bytes with depth 16 → `io_buffer_full` is 1 on the cycle after the 14th push. Push 3 more → count 16 and the 17th byte is dropped. Assert `tx_ready` → 16 bytes drain in order and the flag clears when count < 14.
- **RX read:** `rx_valid=1`, `rx_data=0x7E`, read 0x30000 → `rx_pop` pulses 1 cycle, `mem_din = 0x7E` next cycle. With `rx_valid=0` → `mem_din = 0x00` and no pop.
- **Counter coherence:** preload the counter to `0x000000FF` by running 255 cycles, then read 0x30004..0x30007 on consecutive cycles → bytes `FF, 00, 00, 00`. The carry into byte 1 during the read does not tear the value.
- **Stop and reset:** write 0x30004 → `program_stop=1`, one `0x00` on `tx_data`, counter frozen across 10 cycles. Assert `rst_in=0` mid-drain → all outputs take reset values immediately.
